// File: rtl/rca_16.sv
// 16-bit ripple-carry adder built from one-bit full-adder slices.
// Define RCA_16_OUT_REG_EN to register {co, s} (1-cycle latency, sync active-low reset).
module rca_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] s,
  output logic        co
);

  logic [16:0] w_c;
  logic [15:0] w_s;

  assign w_c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_fa
      logic w_p;
      assign w_p         = x[gi] ^ y[gi];
      assign w_s[gi]     = w_p ^ w_c[gi];
      assign w_c[gi + 1] = (x[gi] & y[gi]) | (w_c[gi] & w_p);
    end
  endgenerate

`ifdef RCA_16_OUT_REG_EN
  logic [16:0] r_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= 17'h0_0000;
    end else begin
      r_sum <= {w_c[16], w_s};
    end
  end

  assign s  = r_sum[15:0];
  assign co = r_sum[16];
`else
  // clk and rst_n stay on the port list so both builds share one footprint.
  logic w_unused;
  assign w_unused = clk ^ rst_n;

  assign s  = w_s;
  assign co = w_c[16];
`endif

endmodule

// File: tb/tb_rca_16.sv
// Directed self-checking bench for rca_16; covers both the combinational
// and the RCA_16_OUT_REG_EN registered build.
module tb_rca_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [15:0] y;
  logic        cin;
  logic [15:0] s;
  logic        co;

  int n_vec = 0;
  int n_err = 0;

  rca_16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .y    (y),
    .cin  (cin),
    .s    (s),
    .co   (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] exp);
    n_vec++;
    $display("vec %-12s x=%04h y=%04h cin=%0b -> co,s=%05h (exp %05h)", tag, x, y, cin, {co, s}, exp);
    assert ({co, s} === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %05h expected %05h", tag, {co, s}, exp);
    end
  endtask

  // Drive a vector, wait 10 ns or one rising edge, then compare.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [16:0] exp);
    x   = a;
    y   = b;
    cin = c;
`ifdef RCA_16_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
    check(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    x     = 16'h0000;
    y     = 16'h0000;
    cin   = 1'b0;

`ifdef RCA_16_OUT_REG_EN
    // Reset wins over capture: nonzero operands are loaded while rst_n=0.
    x   = 16'h1234;
    y   = 16'h4321;
    cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 17'h0_0000);

    rst_n = 1'b1;
    x     = 16'h0001;
    y     = 16'h0001;
    cin   = 1'b1;
    #2;
    check("pre_edge", 17'h0_0000);
    @(posedge clk);
    #1;
    check("one_edge", 17'h0_0003);
`else
    #1;
    check("rst_ignored0", 17'h0_0000);
    apply("rst_ignored1", 16'h0001, 16'h0001, 1'b1, 17'h0_0003);
    rst_n = 1'b1;
`endif

    apply("zero",        16'h0000, 16'h0000, 1'b0, 17'h0_0000);
    apply("ripple_cin1", 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
    apply("ripple_cin0", 16'hFFFF, 16'h0000, 1'b0, 17'h0_FFFF);
    apply("ripple_back", 16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
    apply("alt_bits",    16'hAAAA, 16'h5555, 1'b1, 17'h1_0000);
    apply("mixed",       16'h1234, 16'h4321, 1'b0, 17'h0_5555);
    apply("max_sum",     16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    apply("msb_carry",   16'h8000, 16'h8000, 1'b0, 17'h1_0000);
    apply("mid_carry",   16'h7FFF, 16'h0001, 1'b0, 17'h0_8000);
    apply("nibbles",     16'h00FF, 16'h0F0F, 1'b0, 17'h0_100E);
    apply("compl_cin",   16'h1234, 16'hEDCB, 1'b1, 17'h1_0000);
    apply("top_bits",    16'hC000, 16'h4000, 1'b1, 17'h1_0001);
    apply("cin_only",    16'h0000, 16'h0000, 1'b1, 17'h0_0001);

`ifdef RCA_16_OUT_REG_EN
    // Output holds between edges; mid-cycle reset takes effect only at the edge.
    x   = 16'h0100;
    y   = 16'h0200;
    cin = 1'b0;
    #2;
    check("hold", 17'h0_0001);
    rst_n = 1'b0;
    #2;
    check("rst_mid", 17'h0_0001);
    @(posedge clk);
    #1;
    check("rst_edge", 17'h0_0000);
    rst_n = 1'b1;
    apply("after_rst",   16'h0100, 16'h0200, 1'b0, 17'h0_0300);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rca_16.md
RCA_16 -- requirements
Module: rca_16

Interface
REQ-001 Parameters: none; operand width is fixed at 16 bits.
REQ-002 clk  input  1  single system clock, rising-edge active; used only by the output register (REQ-017).
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 x  input  16  operand A, unsigned.
REQ-005 y  input  16  operand B, unsigned.
REQ-006 cin  input  1  carry-in to bit 0.
REQ-007 s  output  16  sum bits [15:0].
REQ-008 co  output  1  carry-out of bit 15.

Function
REQ-009 {co, s} SHALL equal the 17-bit value x + y + cin for all 2^33 input combinations; no saturation, no signed interpretation.
REQ-010 Structure SHALL be a ripple-carry chain of 16 one-bit full-adder slices; no lookahead, no carry-select, no `+` operator on the 16-bit vectors.
REQ-011 Carry chain: c[0] = cin; for bit i, s[i] = x[i] XOR y[i] XOR c[i] and c[i+1] = (x[i] AND y[i]) OR (c[i] AND (x[i] XOR y[i])); co = c[16].
REQ-012 Without RCA_16_OUT_REG_EN, s and co SHALL be purely combinational: zero cycles of latency, no state.
REQ-013 Without RCA_16_OUT_REG_EN, clk and rst_n SHALL have no effect on the outputs.
REQ-014 Combinational outputs SHALL settle within 10 ns of any input change, including the worst-case full ripple (x=FFFF, y=0000, cin toggling).
REQ-015 Boundary cases: maximum sum FFFF+FFFF+1 SHALL give s=FFFF, co=1; all-zero inputs SHALL give s=0000, co=0.
REQ-016 X or Z on any input bit is not a supported case; the outputs for such inputs are unspecified.

Reset
REQ-017 With RCA_16_OUT_REG_EN, a rising clk edge with rst_n=0 SHALL load s=16'h0000 and co=0.
REQ-018 Reset SHALL take priority over the data capture on the same edge.
REQ-019 Reset is synchronous: asserting rst_n between edges SHALL NOT change the outputs until the next rising edge.
REQ-020 Without RCA_16_OUT_REG_EN, rst_n SHALL be ignored.

Configuration
REQ-021 Macro RCA_16_OUT_REG_EN, when defined, SHALL place a 17-bit register on {co, s}.
REQ-022 With the macro: on each rising clk edge with rst_n=1, the register SHALL capture the combinational chain result; latency is exactly 1 cycle; new inputs are accepted every cycle.
REQ-023 With the macro: outputs SHALL be held between edges; an input change SHALL be visible only after the next rising edge.
REQ-024 Without the macro: combinational behaviour per REQ-012; the clk and rst_n ports SHALL still exist so the port list is identical in both builds.

Verification
REQ-025 The bench SHALL drive each vector, wait 10 ns (combinational build) or one clk edge (registered build), then compare {co, s} against an expected 17-bit value.
REQ-026 The bench SHALL count passes and failures and report the totals.
REQ-027 Scenario: x=0000, y=0000, cin=0 -> s=0000, co=0.
REQ-028 Scenario: x=FFFF, y=0000, cin=1 -> s=0000, co=1 (full 16-bit ripple).
REQ-029 Scenario: x=AAAA, y=5555, cin=1 -> s=0000, co=1; and x=1234, y=4321, cin=0 -> s=5555, co=0.
REQ-030 Scenario: x=FFFF, y=FFFF, cin=1 -> s=FFFF, co=1; and x=8000, y=8000, cin=0 -> s=0000, co=1.
REQ-031 Scenario (macro defined): rst_n=0 for 2 edges -> s=0000, co=0.
REQ-032 Scenario (macro defined): release reset, apply x=0001, y=0001, cin=1 -> s=0003, co=0 after exactly one edge and not before.
